// File: rtl/pmc_dump_unit_if.sv
// Word-stream handshake between the PMC dump unit and the host readout path.
// The master drives the frame words; the slave applies backpressure through dump_ready.
interface pmc_dump_unit_if #(
    parameter int WIDTH = 32
);
    logic             dump_valid;
    logic             dump_ready;
    logic [WIDTH-1:0] dump_data;
    logic [7:0]       dump_index;
    logic             dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_index,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_index,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/pmc_dump_unit.sv
// Snapshots the PMC counter bank on dump_start and streams it out as
// header, counter words and a running-sum checksum over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | waiting for dump_start; no word valid
// SEND_HDR | presenting the header word (index 0)
// SEND_CNT | presenting snapshot[ptr] (index ptr+1)
// SEND_SUM | presenting the checksum (index N+1, dump_last high)
// DONE     | one-cycle completion pulse, then back to IDLE
module pmc_dump_unit #(
    parameter int          NUM_COUNTERS = 26,
    parameter int          WIDTH        = 32,
    parameter logic [15:0] MAGIC        = 16'hA5C3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_COUNTERS*WIDTH-1:0]   counters_in,
    input  logic                            dump_start,
    pmc_dump_unit_if.master                 dump,
    output logic                            busy,
    output logic                            done
);

    localparam int PTR_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
    localparam logic [WIDTH-1:0] HEADER    = {MAGIC, 8'h00, 8'(NUM_COUNTERS)};
    localparam logic [7:0]       SUM_INDEX = 8'(NUM_COUNTERS + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_COUNTERS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_HDR = 3'd1,
        SEND_CNT = 3'd2,
        SEND_SUM = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   snap_q [NUM_COUNTERS];
    logic               sending;
    logic               xfer;

    // Valid is a pure function of state, so ready never reaches an output.
    assign sending = (state_q == SEND_HDR) || (state_q == SEND_CNT) || (state_q == SEND_SUM);
    assign xfer    = sending && dump.dump_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            acc_q   <= '0;
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && dump_start) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    snap_q[i] <= counters_in[i*WIDTH +: WIDTH];
                end
                acc_q <= HEADER;
                ptr_q <= '0;
            end else if (state_q == SEND_CNT && xfer) begin
                acc_q <= acc_q + snap_q[ptr_q];
                ptr_q <= ptr_q + PTR_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (dump_start) state_d = SEND_HDR;
            SEND_HDR: if (xfer) state_d = SEND_CNT;
            SEND_CNT: if (xfer && ptr_q == LAST_PTR) state_d = SEND_SUM;
            SEND_SUM: if (xfer) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        dump.dump_valid = 1'b0;
        dump.dump_data  = '0;
        dump.dump_index = 8'd0;
        dump.dump_last  = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_q)
            SEND_HDR: begin
                dump.dump_valid = 1'b1;
                dump.dump_data  = HEADER;
                busy            = 1'b1;
            end
            SEND_CNT: begin
                dump.dump_valid = 1'b1;
                dump.dump_data  = snap_q[ptr_q];
                dump.dump_index = 8'(ptr_q) + 8'd1;
                busy            = 1'b1;
            end
            SEND_SUM: begin
                dump.dump_valid = 1'b1;
                dump.dump_data  = acc_q;
                dump.dump_index = SUM_INDEX;
                dump.dump_last  = 1'b1;
                busy            = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/pmc_dump_unit.md
# pmc_dump_unit

Reads out the performance-monitoring counter bank (stall, CPI, arithmetic, memory-access and per-instruction counts produced by `PMC_unit`) as one framed word stream. On a start pulse it snapshots every counter in the same cycle, so the frame is self-consistent while the counters keep running. It then emits a header, the counter words and a checksum over a valid/ready handshake. It sits between the PMC bank and the debug/host readout path (UART transmitter or memory-mapped FIFO) and is the consumer end of the PMC counter interface.

## Interface
- `NUM_COUNTERS`, 26: number of 32-bit counters on `counters_in`, 1..254. Order fixed by the PMC bank: stall, CPI num, CPI den, CPI (zero-extended 16-bit), arith, mem access, mem read, mem write, then the 18 per-instruction counts.
- `WIDTH`, 32: counter and stream word width. Fixed at 32; the header layout depends on it.
- `MAGIC`, 16'hA5C3: header tag.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `counters_in`  in  NUM_COUNTERS*32  flattened live counters; counter i is at bits [32*i+31:32*i].
- `dump_start`  in  1  single-cycle request to dump a frame.
- `dump_ready`  in  1  downstream can accept a word.
- `dump_valid`  out  1  `dump_data` is valid.
- `dump_data`  out  32  current frame word.
- `dump_index`  out  8  position of the word in the frame: 0 = header, 1..N = counters, N+1 = checksum.
- `dump_last`  out  1  high with the checksum word.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse after the checksum transfers.

## Operation
- Transfer: a word transfers on a rising edge where `dump_valid && dump_ready`.
- FSM states: IDLE, SEND_HDR, SEND_CNT, SEND_SUM, DONE.
- IDLE:
  - `dump_valid` = 0, `busy` = 0.
  - `dump_start` = 1 loads all N counters into snapshot registers, sets checksum accumulator = header, and goes to SEND_HDR.
- SEND_HDR:
  - Drives the header word = {MAGIC, 8'h00, 8'(NUM_COUNTERS)} with index 0.
  - On transfer, goes to SEND_CNT with word pointer k = 0.
- SEND_CNT:
  - Drives snapshot[k] with index k+1.
  - On transfer, the accumulator adds snapshot[k] mod 2^32 and k increments.
  - The transfer at k = N-1 goes to SEND_SUM.
- SEND_SUM:
  - Drives the accumulator value with index N+1 and `dump_last` = 1.
  - On transfer, goes to DONE.
- DONE:
  - `done` = 1 and `busy` = 1 for exactly one cycle, then IDLE.
- Checksum = (header + Σ snapshot[i]) mod 2^32; carries are discarded.
- `dump_start` while not in IDLE (including DONE) is ignored; it is neither queued nor allowed to re-snapshot.
- Counter changes after the snapshot edge never affect the frame.
- Outputs are registered or decoded from state registers only; there is no combinational path from `dump_ready` to any output.

## Timing
- Reset values: `dump_valid` = 0, `dump_data` = 0, `dump_index` = 0, `dump_last` = 0, `busy` = 0, `done` = 0; state IDLE; snapshot and accumulator cleared.
- Reset asserted mid-frame aborts at the next edge: no `done` pulse; the partial frame is not resumed.
- Start latency: `dump_start` sampled at edge E. At edge E the snapshot is captured, and `dump_valid`/`busy` are high from E until the checksum transfers.
- Throughput: one word per cycle while `dump_ready` is held high.
- Frame with `dump_ready` constantly high: start at edge E, header transfers at E+1, counter k at E+2+k, checksum at E+N+2, `done` high for the cycle after edge E+N+2.
- Total from start to back in IDLE: N+4 edges.
- Backpressure: while `dump_valid && !dump_ready`, `dump_data`, `dump_index` and `dump_last` hold stable; `dump_valid` never drops until the word transfers.
- `dump_ready` is a don't-care in IDLE and DONE.
- `dump_start` and a transfer in the same cycle: no interaction, since start is only honoured in IDLE, where no word is valid.

## Test plan
- Reset/idle: hold `reset` 2 cycles, then idle 5 cycles with `dump_ready` = 1 -> all outputs 0, no `done`.
- Full frame (N=26): counter i = i+1, ready always 1, one start pulse ->
  - 28 words; first word 0xA5C3001A at index 0;
  - words 1..26 at indices 1..26;
  - last word 0xA5C30179 with `dump_last` = 1;
  - `done` one cycle after the last transfer; busy for exactly 29 cycles.
- Snapshot isolation: start, then add 100 to every counter each cycle -> frame identical to the full-frame case.
- Backpressure: toggle `dump_ready` with 1010 and random patterns ->
  - data/index stable while stalled;
  - no word dropped or duplicated;
  - checksum unchanged at 0xA5C30179.
- Ignored start / wrap: re-pulse `dump_start` at index 5 -> single frame only.
  - Separately, all counters 0xFFFFFFFF -> checksum = (0xA5C3001A + 26·0xFFFFFFFF) mod 2^32 = 0xA5C30000.
- Reset mid-frame: assert `reset` at index 10 for 1 cycle -> `dump_valid` = 0 next cycle, no `done`.
  - A new start afterwards yields a complete, correct frame.
